// File: rtl/wwm_pkg.sv
// wwm_pkg: shared definitions for the projectile flight engine.
//   - one-hot flight state encodings
//   - coordinate / position / velocity widths
//   - play-field bounds and target box
//   - small combinational helpers for outcome checks, clamping and saturation
package wwm_pkg;

  localparam int unsigned COORD_W = 10;  // on-screen coordinate width
  localparam int unsigned POS_W   = 13;  // signed working width for x'/y'
  localparam int unsigned VEL_W   = 8;   // signed velocity register width
  localparam int unsigned IN_W    = 4;   // signed launch velocity / wind width

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_FLIGHT = 4'b0010,
    ST_HIT    = 4'b0100,
    ST_MISS   = 4'b1000
  } state_e;

  // Play-field bounds: reaching or passing any of these is a miss.
  localparam logic signed [POS_W-1:0] FIELD_X_MIN = 13'sd160;
  localparam logic signed [POS_W-1:0] FIELD_X_MAX = 13'sd775;
  localparam logic signed [POS_W-1:0] FIELD_Y_MIN = 13'sd50;
  localparam logic signed [POS_W-1:0] FIELD_Y_MAX = 13'sd475;

  // Target box, inclusive on all sides.
  localparam logic signed [POS_W-1:0] TGT_X_LO = 13'sd650;
  localparam logic signed [POS_W-1:0] TGT_X_HI = 13'sd675;
  localparam logic signed [POS_W-1:0] TGT_Y_LO = 13'sd470;
  localparam logic signed [POS_W-1:0] TGT_Y_HI = 13'sd475;

  localparam logic signed [POS_W-1:0] COORD_MAX = 13'sd1023;

  // Target box test on a freshly integrated position.
  function automatic logic in_target(input logic signed [POS_W-1:0] x,
                                     input logic signed [POS_W-1:0] y);
    return (x >= TGT_X_LO) && (x <= TGT_X_HI) && (y >= TGT_Y_LO) && (y <= TGT_Y_HI);
  endfunction

  // Field exit test; negative coordinates fall under the <= minimum terms.
  function automatic logic out_of_field(input logic signed [POS_W-1:0] x,
                                        input logic signed [POS_W-1:0] y);
    return (x >= FIELD_X_MAX) || (x <= FIELD_X_MIN) ||
           (y >= FIELD_Y_MAX) || (y <= FIELD_Y_MIN);
  endfunction

  // Clamp a signed working position into the visible coordinate range.
  function automatic logic [COORD_W-1:0] clamp_coord(input logic signed [POS_W-1:0] v);
    if (v < 0)              return '0;
    else if (v > COORD_MAX) return '1;
    else                    return v[COORD_W-1:0];
  endfunction

  // Saturate a one-bit-wider velocity result back into the velocity register range.
  function automatic logic signed [VEL_W-1:0] sat_vel(input logic signed [VEL_W:0] v);
    if (v > 9'sd127)       return 8'sd127;
    else if (v < -9'sd128) return -8'sd128;
    else                   return v[VEL_W-1:0];
  endfunction

endpackage

// File: rtl/wwm_projectile.sv
// wwm_projectile: projectile flight engine for the worms-style game.
// Latches a launch velocity on Fire, integrates position with gravity on each
// frame Tick, and reports the outcome as a one-cycle Hit or Miss pulse.
// Optional feature: define WWM_PROJ_WIND_EN to add the Wind port, which
// accelerates vxCur by Wind every Tick in flight (saturating).
// Ports:
//   clk                in   system clock
//   Reset_n            in   asynchronous active-low reset
//   Tick               in   one-cycle frame strobe
//   Fire               in   one-cycle launch request (honoured only when idle)
//   vX, vY             in   signed launch velocity, px/Tick (+X right, +Y up)
//   Wind               in   signed wind (WWM_PROJ_WIND_EN only)
//   projectileCenterX  out  current centre X, clamped to [0,1023]
//   projectileCenterY  out  current centre Y, clamped to [0,1023]
//   Active             out  projectile in flight
//   Hit, Miss          out  one-cycle outcome pulses
module wwm_projectile
  import wwm_pkg::*;
#(
  parameter int unsigned START_X = 200,
  parameter int unsigned START_Y = 440,
  parameter int unsigned GRAVITY = 1
) (
  input  logic               clk,
  input  logic               Reset_n,
  input  logic               Tick,
  input  logic               Fire,
  input  logic [IN_W-1:0]    vX,
  input  logic [IN_W-1:0]    vY,
`ifdef WWM_PROJ_WIND_EN
  input  logic [IN_W-1:0]    Wind,
`endif
  output logic [COORD_W-1:0] projectileCenterX,
  output logic [COORD_W-1:0] projectileCenterY,
  output logic               Active,
  output logic               Hit,
  output logic               Miss
);

  state_e                    state_q, state_d;
  logic [COORD_W-1:0]        cx_q, cx_d, cy_q, cy_d;
  logic signed [VEL_W-1:0]   vx_q, vx_d, vy_q, vy_d;

  logic signed [POS_W-1:0]   x_new, y_new;
  logic signed [VEL_W:0]     vy_grav;
`ifdef WWM_PROJ_WIND_EN
  logic signed [VEL_W:0]     vx_wind;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      cx_q    <= COORD_W'(START_X);
      cy_q    <= COORD_W'(START_Y);
      vx_q    <= '0;
      vy_q    <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
    end
  end

  // Candidate next position and velocities; only committed on a Tick in flight.
  // The held centre is always inside the field while flying, so integrating
  // from the clamped 10-bit value is exact.
  always_comb begin
    x_new   = {{(POS_W-COORD_W){1'b0}}, cx_q} + {{(POS_W-VEL_W){vx_q[VEL_W-1]}}, vx_q};
    y_new   = {{(POS_W-COORD_W){1'b0}}, cy_q} - {{(POS_W-VEL_W){vy_q[VEL_W-1]}}, vy_q};
    vy_grav = {vy_q[VEL_W-1], vy_q} - (VEL_W+1)'(GRAVITY);
`ifdef WWM_PROJ_WIND_EN
    vx_wind = {vx_q[VEL_W-1], vx_q} + {{(VEL_W+1-IN_W){Wind[IN_W-1]}}, Wind};
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Fire) begin
          vx_d    = {{(VEL_W-IN_W){vX[IN_W-1]}}, vX};
          vy_d    = {{(VEL_W-IN_W){vY[IN_W-1]}}, vY};
          cx_d    = COORD_W'(START_X);
          cy_d    = COORD_W'(START_Y);
          state_d = ST_FLIGHT;
        end
      end
      ST_FLIGHT: begin
        if (Tick) begin
          cx_d = clamp_coord(x_new);
          cy_d = clamp_coord(y_new);
          vy_d = sat_vel(vy_grav);
`ifdef WWM_PROJ_WIND_EN
          vx_d = sat_vel(vx_wind);
`endif
          // Hit takes priority: the target box touches the lower field edge.
          if (in_target(x_new, y_new))         state_d = ST_HIT;
          else if (out_of_field(x_new, y_new)) state_d = ST_MISS;
        end
      end
      ST_HIT, ST_MISS: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  // Status outputs are the one-hot state flops themselves.
  assign Active            = state_q[1];
  assign Hit               = state_q[2];
  assign Miss              = state_q[3];
  assign projectileCenterX = cx_q;
  assign projectileCenterY = cy_q;

endmodule

// File: tb/tb_wwm_projectile.sv
// tb_wwm_projectile: directed bench for wwm_projectile.
// Instance u_a uses the default launch point (200,440); instance u_b launches
// from (660,460) to reach the target box. Define WWM_PROJ_WIND_EN to add the wind case.
module tb_wwm_projectile;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       Tick;
  logic       fire_a, fire_b;
  logic [3:0] vX, vY;
`ifdef WWM_PROJ_WIND_EN
  logic [3:0] wind;
`endif
  logic [9:0] ax, ay, bx, by;
  logic       a_active, a_hit, a_miss, b_active, b_hit, b_miss;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wwm_projectile u_a (
    .clk(clk), .Reset_n(Reset_n), .Tick(Tick), .Fire(fire_a), .vX(vX), .vY(vY),
`ifdef WWM_PROJ_WIND_EN
    .Wind(wind),
`endif
    .projectileCenterX(ax), .projectileCenterY(ay),
    .Active(a_active), .Hit(a_hit), .Miss(a_miss)
  );

  wwm_projectile #(.START_X(660), .START_Y(460)) u_b (
    .clk(clk), .Reset_n(Reset_n), .Tick(Tick), .Fire(fire_b), .vX(vX), .vY(vY),
`ifdef WWM_PROJ_WIND_EN
    .Wind(wind),
`endif
    .projectileCenterX(bx), .projectileCenterY(by),
    .Active(b_active), .Hit(b_hit), .Miss(b_miss)
  );

  task automatic check_vec(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Fire one instance (0 = u_a, 1 = u_b), optionally with a coincident Tick.
  task automatic launch(input int which, input int vx, input int vy, input bit with_tick);
    @(negedge clk);
    vX = 4'(vx);
    vY = 4'(vy);
    if (which == 0) fire_a = 1'b1; else fire_b = 1'b1;
    Tick = with_tick;
    @(negedge clk);
    fire_a = 1'b0;
    fire_b = 1'b0;
    Tick   = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    Tick = 1'b1;
    @(negedge clk);
    Tick = 1'b0;
  endtask

  task automatic check_a(input string tag, input int x, input int y,
                         input int act, input int hit, input int miss);
    check_vec({tag, ".x"}, int'(ax), x);
    check_vec({tag, ".y"}, int'(ay), y);
    check_vec({tag, ".active"}, int'(a_active), act);
    check_vec({tag, ".hit"}, int'(a_hit), hit);
    check_vec({tag, ".miss"}, int'(a_miss), miss);
  endtask

  int ytab2 [9] = '{440, 441, 443, 446, 450, 455, 461, 468, 476};
  int ytab3 [5] = '{460, 461, 463, 466, 470};
  int xtab5 [5] = '{192, 184, 176, 168, 160};
  int ytab5 [5] = '{433, 427, 422, 418, 415};

  initial begin
    Reset_n = 1'b0;
    Tick    = 1'b0;
    fire_a  = 1'b0;
    fire_b  = 1'b0;
    vX      = '0;
    vY      = '0;
`ifdef WWM_PROJ_WIND_EN
    wind    = '0;
`endif
    repeat (2) @(negedge clk);

    // Reset state
    check_a("rst", 200, 440, 0, 0, 0);
    check_vec("rst.bx", int'(bx), 660);
    check_vec("rst.by", int'(by), 460);
    Reset_n = 1'b1;

    // Tick while idle has no effect
    pulse_tick();
    check_a("idle_tick", 200, 440, 0, 0, 0);

    // Mid-flight async reset aborts with no outcome pulse
    launch(0, 7, 0, 1'b0);
    check_vec("rst_mid.launch_active", int'(a_active), 1);
    repeat (3) pulse_tick();
    check_vec("rst_mid.pre_y", int'(ay), 443);
    @(posedge clk);
    #2 Reset_n = 1'b0;
    #1 check_a("rst_mid", 200, 440, 0, 0, 0);
    @(negedge clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_a("rst_mid.after", 200, 440, 0, 0, 0);
    end

    // Launch vX=7,vY=0, with a Fire of vX=-8 during flight that must be ignored
    launch(0, 7, 0, 1'b0);
    check_a("flat.launch", 200, 440, 1, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      if (k == 3) launch(0, -8, 0, 1'b0);
      pulse_tick();
      check_a($sformatf("flat.t%0d", k), 200 + 7 * k, ytab2[k-1],
              (k < 9) ? 1 : 0, 0, (k == 9) ? 1 : 0);
    end
    @(negedge clk);
    check_a("flat.after", 263, 476, 0, 0, 0);
    pulse_tick();
    check_a("flat.idle_hold", 263, 476, 0, 0, 0);

    // Second Fire after Miss, coincident with Tick: launch only, reload to start
    launch(0, -8, 7, 1'b1);
    check_a("left.launch", 200, 440, 1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      pulse_tick();
      check_a($sformatf("left.t%0d", k), xtab5[k-1], ytab5[k-1],
              (k < 5) ? 1 : 0, 0, (k == 5) ? 1 : 0);
    end
    @(negedge clk);
    check_a("left.after", 160, 415, 0, 0, 0);

    // Drop into the target box from (660,460)
    launch(1, 0, 0, 1'b0);
    check_vec("drop.launch_active", int'(b_active), 1);
    for (int k = 1; k <= 5; k++) begin
      pulse_tick();
      check_vec($sformatf("drop.t%0d.x", k), int'(bx), 660);
      check_vec($sformatf("drop.t%0d.y", k), int'(by), ytab3[k-1]);
      check_vec($sformatf("drop.t%0d.hit", k), int'(b_hit), (k == 5) ? 1 : 0);
      check_vec($sformatf("drop.t%0d.miss", k), int'(b_miss), 0);
    end
    @(negedge clk);
    check_vec("drop.after.hit", int'(b_hit), 0);
    check_vec("drop.after.active", int'(b_active), 0);
    check_vec("drop.after.y", int'(by), 470);

`ifdef WWM_PROJ_WIND_EN
    // Wind accelerates x after each position update
    wind = 4'd2;
    launch(0, 0, 0, 1'b0);
    begin
      int wx [4] = '{200, 202, 206, 212};
      for (int k = 1; k <= 4; k++) begin
        pulse_tick();
        check_vec($sformatf("wind.t%0d.x", k), int'(ax), wx[k-1]);
        check_vec($sformatf("wind.t%0d.y", k), int'(ay), ytab2[k-1]);
      end
    end
    wind = '0;
    Reset_n = 1'b0;
    @(negedge clk);
    Reset_n = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
